// File: rtl/ysyx_22050243_load_extend_pkg.sv
// Shared encodings for the load-extend block: access size codes.
package ysyx_22050243_load_extend_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

endpackage

// File: rtl/ysyx_22050243_load_extend_field_ext.sv
// Combinational field extraction: shift the addressed bytes down, then
// zero- or sign-fill above the field; misaligned or illegal sizes give 0 + err.
module ysyx_22050243_field_ext
  import ysyx_22050243_load_extend_pkg::*;
#(
  parameter  int DATA_W = 64,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  output logic [DATA_W-1:0] o_data,
  output logic              o_err
);

  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_mask;
  logic [OFF_W-1:0]  w_align;
  logic              w_msb;
  logic              w_illegal;

  assign w_shifted = i_data >> {i_off, 3'b000};

  // w_mask covers the field bits; w_align holds offset bits that must be zero.
  always_comb begin
    w_mask    = '1;
    w_align   = '0;
    w_msb     = 1'b0;
    w_illegal = 1'b0;
    case (size_e'(i_size))
      SZ_B: begin
        w_mask = DATA_W'(8'hFF);
        w_msb  = w_shifted[7];
      end
      SZ_H: begin
        w_mask  = DATA_W'(16'hFFFF);
        w_align = OFF_W'(1);
        w_msb   = w_shifted[15];
      end
      SZ_W: begin
        w_mask  = DATA_W'(32'hFFFF_FFFF);
        w_align = OFF_W'(3);
        w_msb   = w_shifted[31];
      end
      SZ_D: begin
        w_align   = OFF_W'(7);
        w_illegal = (DATA_W == 32);
      end
      default: ;
    endcase
  end

  assign o_err  = w_illegal | (|(i_off & w_align));
  assign o_data = o_err ? '0
                : ((w_shifted & w_mask) | ({DATA_W{i_signed & w_msb}} & ~w_mask));

endmodule

// File: rtl/ysyx_22050243_load_extend.sv
// Load-extend stage: extracts/extends on accept and buffers results in a small
// FIFO; in_ready is registered so it never depends on out_ready in-cycle.
module ysyx_22050243_load_extend
  import ysyx_22050243_load_extend_pkg::*;
#(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 2,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic              r_mem_err  [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_next;
  logic              r_in_ready;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_ext_data;
  logic              w_ext_err;

  ysyx_22050243_field_ext #(
    .DATA_W (DATA_W)
  ) u_field_ext (
    .i_data   (in_data),
    .i_off    (in_off),
    .i_size   (in_size),
    .i_signed (in_signed),
    .o_data   (w_ext_data),
    .o_err    (w_ext_err)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & r_in_ready;
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Ready for next cycle is derived from next count, so it tracks count < DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next < CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= w_ext_data;
      r_mem_err[r_wptr]  <= w_ext_err;
    end
  end

  // Gate with out_valid so an empty (or freshly reset) buffer shows zeros.
  assign out_data = out_valid ? r_mem_data[r_rptr] : '0;
  assign out_err  = out_valid ? r_mem_err[r_rptr]  : 1'b0;

endmodule

// File: tb/tb_ysyx_22050243_load_extend.sv
// Bench for the load-extend stage: directed vectors, a byte-level reference
// model with an in-order scoreboard, and a small 32-bit instance.
module tb_ysyx_22050243_load_extend;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [2:0]  in_off = '0;
  logic [1:0]  in_size = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic        out_err;

  logic        v32 = 1'b0;
  logic        rdy32;
  logic [31:0] d32 = '0;
  logic [1:0]  off32 = '0;
  logic [1:0]  sz32 = '0;
  logic        sg32 = 1'b0;
  logic        ov32;
  logic        ordy32 = 1'b1;
  logic [31:0] od32;
  logic        oe32;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int stream_max = 0;
  bit stream_on = 1'b0;
  bit last_edge_rst = 1'b1;
  logic [64:0] exp_q[$];

  typedef struct {
    logic [63:0] d;
    int          off;
    int          sz;
    bit          sg;
    logic [63:0] exp;
    bit          err;
  } vec_t;
  vec_t vt[$];

  ysyx_22050243_load_extend #(.DATA_W(64), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_off(in_off), .in_size(in_size), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  ysyx_22050243_load_extend #(.DATA_W(32), .DEPTH(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32),
    .in_data(d32), .in_off(off32), .in_size(sz32), .in_signed(sg32),
    .out_valid(ov32), .out_ready(ordy32), .out_data(od32), .out_err(oe32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) last_edge_rst <= !rst_n;

  // Reference: build the result bit by bit from the addressed bytes.
  function automatic logic [64:0] model(input logic [63:0] d, input int off,
                                        input int size, input bit sgn, input int w);
    int nb = 1 << size;
    logic [63:0] r = '0;
    bit msb;
    if ((size == 3 && w == 32) || (off % nb) != 0) return {1'b1, 64'd0};
    msb = d[8*off + 8*nb - 1];
    for (int i = 0; i < w; i++) r[i] = (i < 8*nb) ? d[8*off + i] : (sgn & msb);
    return {1'b0, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (last_edge_rst) begin
      exp_q.delete();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
    end else begin
      chk("mon_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      chk("mon_in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
      if (stream_on && exp_q.size() > stream_max) stream_max = exp_q.size();
      if (out_valid && exp_q.size() != 0) begin
        chk("mon_out_data", out_data, exp_q[0][63:0]);
        chk("mon_out_err", 64'(out_err), 64'(exp_q[0][64]));
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_data, int'(in_off), int'(in_size), in_signed, 64));
    end
  end

  // Called #1 after an edge; leaves in_valid high so calls can run back to back.
  task automatic send(input logic [63:0] d, input int off, input int sz, input bit sg);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_off = 3'(off); in_size = 2'(sz); in_signed = sg;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    $display("req data=%h off=%0d size=%0d signed=%0d accepted", d, off, sz, sg);
  endtask

  task automatic send32(input logic [31:0] d, input int off, input int sz, input bit sg,
                        input logic [31:0] exp, input bit err);
    logic [64:0] m;
    chk("rdy32", 64'(rdy32), 64'd1);
    v32 = 1'b1; d32 = d; off32 = 2'(off); sz32 = 2'(sz); sg32 = sg;
    @(posedge clk); #1;
    v32 = 1'b0;
    m = model({32'd0, d}, off, sz, sg, 32);
    chk("dut32_valid", 64'(ov32), 64'd1);
    chk("dut32_data", 64'(od32), 64'(exp));
    chk("dut32_err", 64'(oe32), 64'(err));
    chk("model32_pin", m, {err, 32'd0, exp});
    $display("dut32 data=%h off=%0d size=%0d -> %h err=%0d", d, off, sz, od32, oe32);
  endtask

  initial begin
    int p0;
    time t0;
    vt.push_back('{64'h0000_0000_0000_80FF, 1, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0});
    vt.push_back('{64'h8001_0000_0000_0000, 6, 1, 1'b0, 64'h0000_0000_0000_8001, 1'b0});
    vt.push_back('{64'hDEAD_BEEF_CAFE_F00D, 2, 2, 1'b1, 64'h0, 1'b1});
    vt.push_back('{64'h0123_4567_89AB_CDEF, 2, 1, 1'b1, 64'hFFFF_FFFF_FFFF_89AB, 1'b0});
    vt.push_back('{64'h0123_4567_89AB_CDEF, 4, 2, 1'b1, 64'h0000_0000_0123_4567, 1'b0});
    vt.push_back('{64'h0123_4567_89AB_CDEF, 0, 2, 1'b1, 64'hFFFF_FFFF_89AB_CDEF, 1'b0});
    vt.push_back('{64'h0123_4567_89AB_CDEF, 0, 3, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0});
    vt.push_back('{64'h0123_4567_89AB_CDEF, 4, 3, 1'b0, 64'h0, 1'b1});
    vt.push_back('{64'h0123_4567_89AB_CDEF, 3, 1, 1'b0, 64'h0, 1'b1});
    vt.push_back('{64'h0123_4567_89AB_CDEF, 7, 0, 1'b0, 64'h0000_0000_0000_0001, 1'b0});
    vt.push_back('{64'h0123_4567_89AB_CDEF, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFEF, 1'b0});
    vt.push_back('{64'h0123_4567_89AB_CDEF, 6, 1, 1'b1, 64'h0000_0000_0000_0123, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    chk("model_signed_byte", model(64'h80FF, 1, 0, 1'b1, 64), {1'b0, 64'hFFFF_FFFF_FFFF_FF80});
    chk("model_unsigned_half", model(64'h8001_0000_0000_0000, 6, 1, 1'b0, 64), {1'b0, 64'h8001});
    chk("model_misaligned", model(64'h1234, 2, 2, 1'b1, 64), {1'b1, 64'd0});
    chk("model_d_on_32", model(64'h1234, 0, 3, 1'b0, 32), {1'b1, 64'd0});

    foreach (vt[i]) begin
      send(vt[i].d, vt[i].off, vt[i].sz, vt[i].sg);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_data", i), out_data, vt[i].exp);
      chk($sformatf("vec%0d_err", i), 64'(out_err), 64'(vt[i].err));
    end
    @(posedge clk); #1;

    // Backpressure: fill two entries, hold a third request off.
    p0 = pops;
    out_ready = 1'b0;
    send(64'h1122_3344_5566_7788, 0, 0, 1'b0);
    send(64'h1122_3344_5566_7788, 1, 0, 1'b1);
    in_valid = 1'b1; in_data = 64'h1122_3344_5566_7788; in_off = 3'd4; in_size = 2'd2; in_signed = 1'b0;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("held_in_ready", 64'(in_ready), 64'd0);
      chk("held_out_data", out_data, 64'h88);
    end
    out_ready = 1'b1;
    send(64'h1122_3344_5566_7788, 4, 2, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", 64'(pops - p0), 64'd3);

    // Streaming: eight back-to-back requests with the consumer always ready.
    p0 = pops; stream_max = 0; stream_on = 1'b1;
    t0 = $time;
    for (int k = 0; k < 8; k++)
      send(64'hF0E1_D2C3_B4A5_9687 + 64'(k * 64'h0101_0101), k % 8, k % 3, k[0]);
    chk("stream_cycles", 64'($time - t0), 64'd80);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    stream_on = 1'b0;
    chk("stream_results", 64'(pops - p0), 64'd8);
    chk("stream_max_count", 64'(stream_max), 64'd1);

    // Reset with two results buffered.
    out_ready = 1'b0;
    send(64'hAAAA_BBBB_CCCC_DDDD, 0, 3, 1'b0);
    send(64'h1111_2222_3333_4444, 0, 1, 1'b0);
    in_valid = 1'b0;
    chk("pre_reset_full", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_flush_valid", 64'(out_valid), 64'd0);
    chk("reset_flush_data", out_data, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_midreset", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_stale_result", 64'(out_valid), 64'd0);
    end

    send32(32'h8000_0000, 0, 2, 1'b1, 32'h8000_0000, 1'b0);
    send32(32'hAB00_0000, 3, 0, 1'b1, 32'hFFFF_FFAB, 1'b0);
    send32(32'h1234_5678, 0, 3, 1'b0, 32'h0, 1'b1);
    send32(32'h1234_5678, 2, 1, 1'b1, 32'h0000_1234, 1'b0);
    send32(32'h1234_5678, 1, 1, 1'b0, 32'h0, 1'b1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22050243_load_extend.md
YSYX_22050243_LOAD_EXTEND -- requirements
Module: ysyx_22050243_load_extend

Interface
REQ-001 SHALL have parameter DATA_W, default 64, load data width in bits; legal values 32 or 64 only.
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries; legal values 2 or 4.
REQ-003 SHALL derive localparam OFF_W = log2(DATA_W/8) as the byte-offset width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, request present.
REQ-007 SHALL have port in_ready, output, 1, block accepts a request this cycle.
REQ-008 SHALL have port in_data, input, DATA_W, raw aligned memory word.
REQ-009 SHALL have port in_off, input, OFF_W, byte offset of the access within in_data.
REQ-010 SHALL have port in_size, input, 2, access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-011 SHALL have port in_signed, input, 1, 1 = sign-extend, 0 = zero-extend.
REQ-012 SHALL have port out_valid, output, 1, result present.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-014 SHALL have port out_data, output, DATA_W, extracted and extended result.
REQ-015 SHALL have port out_err, output, 1, access was misaligned or of illegal size.

Function
REQ-016 A request SHALL transfer when in_valid and in_ready are both 1; a result SHALL transfer when out_valid and out_ready are both 1.
REQ-017 The field SHALL be in_data bits [8*in_off + (8<<in_size) - 1 : 8*in_off].
REQ-018 out_data SHALL be the field padded to DATA_W bits: with the field MSB when in_signed = 1, with zeros when in_signed = 0; size D SHALL pass the field unchanged.
REQ-019 out_err SHALL be 1 and out_data SHALL be 0 when in_off is not a multiple of (1<<in_size), or when in_size = 3 and DATA_W = 32.
REQ-020 Extract and extend SHALL be computed on accept; the result SHALL be written into a FIFO of DEPTH entries.
REQ-021 The FIFO head SHALL drive out_data and out_err; out_valid SHALL be 1 whenever the FIFO count is nonzero.
REQ-022 Latency SHALL be 1 cycle: a request accepted in cycle N into an empty FIFO SHALL give out_valid = 1 in cycle N+1.
REQ-023 in_ready SHALL be the registered value of (count < DEPTH); it SHALL NOT depend combinationally on out_ready.
REQ-024 Throughput SHALL be 1 result per cycle while out_ready stays at 1.
REQ-025 When push and pop happen in the same cycle, count SHALL stay unchanged.
REQ-026 When count = DEPTH, in_ready SHALL be 0 and no push SHALL occur, even if a pop happens in the same cycle.
REQ-027 Results SHALL leave in acceptance order; read and write pointers SHALL wrap modulo DEPTH.
REQ-028 While out_valid = 1 and out_ready = 0, out_data and out_err SHALL hold stable.

Reset
REQ-029 While rst_n = 0 at a clock edge, the block SHALL clear count and both pointers to 0 and drive out_valid = 0, out_data = 0, out_err = 0 and in_ready = 0.
REQ-030 In the first cycle after rst_n returns to 1, in_ready SHALL be 1.
REQ-031 A reset mid-operation SHALL discard all buffered results; no stale result SHALL appear afterwards.

Structure
REQ-032 A shared package SHALL hold the size encodings SZ_B = 0, SZ_H = 1, SZ_W = 2, SZ_D = 3.
REQ-033 The extract-and-extend logic SHALL be a combinational sub-module, ysyx_22050243_field_ext, parameterised by DATA_W.
REQ-034 The FIFO and handshake logic SHALL be in the top module.

Verification
REQ-035 Signed byte: in_data = 0x00000000_0000_80FF, off 1, size B, signed -> out_data = 0xFFFFFFFF_FFFFFF80, out_err = 0, one cycle after accept.
REQ-036 Unsigned half: in_data = 0x8001_0000_0000_0000, off 6, size H, unsigned -> out_data = 0x00000000_00008001.
REQ-037 Misaligned word: off 2, size W -> out_err = 1, out_data = 0; with DATA_W = 32 and size D -> out_err = 1.
REQ-038 Backpressure: out_ready = 0, push 3 requests with DEPTH = 2 -> in_ready = 0 after the 2nd accept, the 3rd is held; then out_ready = 1 -> results drain in order with no loss.
REQ-039 Streaming: out_ready held at 1 and 8 back-to-back requests -> 8 results in 8 consecutive cycles, count never above 1.
REQ-040 Reset with 2 entries buffered -> out_valid = 0 in the following cycle, in_ready = 1 after rst_n rises, and no old data appears.
